filtro_temperatura: RTL and testbench

- Upstream conditioning stage for the temperature monitor. Accepts raw signed 11-bit sensor samples and rejects out-of-range values. Produces a moving average over 2^LOG2_N samples on temp_filtrada, which drives the monitor's temp_entrada.
- Flags a sensor fault after a run of consecutive rejected samples.

---
 rtl/filtro_pkg.sv | 25 ++
 rtl/filtro_ventana.sv | 61 ++++++
 rtl/filtro_temperatura.sv | 132 +++++++++++++
 tb/tb_filtro_temperatura.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared types and default limits for the temperature conditioning filter.
package filtro_pkg;

  typedef logic signed [10:0] temp_t;

  typedef enum logic [1:0] {
    VACIO    = 2'b00,
    OPERANDO = 2'b01,
    FALLA    = 2'b10
  } estado_filtro_t;

  localparam int LOG2_N_DEF       = 3;
  localparam int TEMP_MIN_DEF     = -400;
  localparam int TEMP_MAX_DEF     = 1000;
  localparam int MAX_RECHAZOS_DEF = 4;
  localparam int DELTA_MAX_DEF    = 50;

  // 12 bits hold every difference of two 11-bit signed values, so no overflow.
  function automatic logic [11:0] dif_abs(input temp_t a, input temp_t b);
    logic signed [11:0] d;
    d = {a[10], a} - {b[10], b};
    return d[11] ? 12'(-d) : 12'(d);
  endfunction

endpackage

// File: rtl/filtro_ventana.sv
// Circular sample window with running sum; o_media is the next floor average.
// Combinational next-sum view, state updates on the capture edge; no backpressure.
module filtro_ventana
  import filtro_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic  clk,
  input  logic  arst_n,
  input  logic  i_prime,
  input  logic  i_push,
  input  temp_t i_dato,
  output temp_t o_media
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 11 + LOG2_N;

  temp_t                r_buf [N];
  logic [LOG2_N-1:0]    r_ptr;
  logic signed [SW-1:0] r_suma;
  logic signed [SW-1:0] w_suma_sig;
  logic signed [SW-1:0] w_dato_ext;
  logic signed [SW-1:0] w_viejo_ext;

  assign w_dato_ext  = {{LOG2_N{i_dato[10]}}, i_dato};
  assign w_viejo_ext = {{LOG2_N{r_buf[r_ptr][10]}}, r_buf[r_ptr]};

  always_comb begin
    w_suma_sig = r_suma;
    if (i_prime) begin
      w_suma_sig = w_dato_ext <<< LOG2_N;
    end else if (i_push) begin
      w_suma_sig = r_suma - w_viejo_ext + w_dato_ext;
    end
  end

  // The top 11 bits of the sum are exactly sum >>> LOG2_N (floor toward -inf).
  assign o_media = w_suma_sig[SW-1:LOG2_N];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr  <= '0;
      r_suma <= '0;
    end else if (i_prime) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= i_dato;
      end
      r_ptr  <= '0;
      r_suma <= w_suma_sig;
    end else if (i_push) begin
      r_buf[r_ptr] <= i_dato;
      r_ptr        <= r_ptr + 1'b1;
      r_suma       <= w_suma_sig;
    end
  end

endmodule

// File: rtl/filtro_temperatura.sv
// Range-checked moving average of raw sensor samples with fault detection; FILTRO_PICO_EN adds spike rejection.
// Output registered on the edge that captures an accepted sample; no backpressure, one sample per strobe.
module filtro_temperatura
  import filtro_pkg::*;
#(
  parameter int LOG2_N       = LOG2_N_DEF,
  parameter int TEMP_MIN     = TEMP_MIN_DEF,
  parameter int TEMP_MAX     = TEMP_MAX_DEF,
  parameter int MAX_RECHAZOS = MAX_RECHAZOS_DEF
`ifdef FILTRO_PICO_EN
  ,
  parameter int DELTA_MAX    = DELTA_MAX_DEF
`endif
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        muestra_valida,
  input  logic [10:0] muestra,
  output logic [10:0] temp_filtrada,
  output logic        salida_valida,
  output logic        falla_sensor,
  output logic [1:0]  estado
);

  localparam temp_t      C_MIN = temp_t'(TEMP_MIN);
  localparam temp_t      C_MAX = temp_t'(TEMP_MAX);
  localparam logic [3:0] C_REC = 4'(MAX_RECHAZOS);

  estado_filtro_t r_estado, w_estado_sig;
  logic [3:0]     r_rechazos, w_rechazos_sig, w_rechazos_inc;
  temp_t          r_temp;
  logic           r_vld;

  temp_t w_muestra;
  temp_t w_media;
  logic  w_en_rango, w_pico, w_acepta, w_rechaza;
  logic  w_prime, w_push;

  assign w_muestra  = temp_t'(muestra);
  assign w_en_rango = (w_muestra >= C_MIN) && (w_muestra <= C_MAX);

`ifdef FILTRO_PICO_EN
  localparam logic [11:0] C_DELTA = 12'(DELTA_MAX);
  logic [11:0] w_dif_abs;

  assign w_dif_abs = dif_abs(w_muestra, r_temp);
  assign w_pico    = (r_estado == OPERANDO) && (w_dif_abs > C_DELTA);
`else
  assign w_pico = 1'b0;
`endif

  assign w_acepta  = muestra_valida && w_en_rango && !w_pico;
  assign w_rechaza = muestra_valida && !w_acepta;

  // Saturating count of consecutive rejects; gaps without a strobe do not count.
  assign w_rechazos_inc = (r_rechazos >= C_REC) ? C_REC : r_rechazos + 4'd1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_estado   <= VACIO;
      r_rechazos <= '0;
    end else begin
      r_estado   <= w_estado_sig;
      r_rechazos <= w_rechazos_sig;
    end
  end

  always_comb begin
    w_estado_sig   = r_estado;
    w_rechazos_sig = r_rechazos;
    w_prime        = 1'b0;
    w_push         = 1'b0;
    case (r_estado)
      VACIO, FALLA: begin
        if (w_acepta) begin
          w_prime        = 1'b1;
          w_rechazos_sig = '0;
          w_estado_sig   = OPERANDO;
        end else if (w_rechaza) begin
          w_rechazos_sig = w_rechazos_inc;
          if (w_rechazos_inc == C_REC) begin
            w_estado_sig = FALLA;
          end
        end
      end
      OPERANDO: begin
        if (w_acepta) begin
          w_push         = 1'b1;
          w_rechazos_sig = '0;
        end else if (w_rechaza) begin
          w_rechazos_sig = w_rechazos_inc;
          if (w_rechazos_inc == C_REC) begin
            w_estado_sig = FALLA;
          end
        end
      end
      default: begin
        w_estado_sig   = VACIO;
        w_rechazos_sig = '0;
      end
    endcase
  end

  filtro_ventana #(
    .LOG2_N (LOG2_N)
  ) u_ventana (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_prime (w_prime),
    .i_push  (w_push),
    .i_dato  (w_muestra),
    .o_media (w_media)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_temp <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_acepta;
      if (w_acepta) begin
        r_temp <= w_media;
      end
    end
  end

  assign temp_filtrada = r_temp;
  assign salida_valida = r_vld;
  assign falla_sensor  = (r_estado == FALLA);
  assign estado        = r_estado;

endmodule

// File: tb/tb_filtro_temperatura.sv
// Scoreboard bench for filtro_temperatura: directed scenarios plus random samples against a queue-based average model.
module tb_filtro_temperatura;

  localparam int N     = 8;
  localparam int LMIN  = -400;
  localparam int LMAX  = 1000;
  localparam int MAXR  = 4;
  localparam int DELTA = 50;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        muestra_valida = 1'b0;
  logic [10:0] muestra = '0;
  logic [10:0] temp_filtrada;
  logic        salida_valida;
  logic        falla_sensor;
  logic [1:0]  estado;

  always #5 clk = ~clk;

  filtro_temperatura dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .muestra_valida (muestra_valida),
    .muestra        (muestra),
    .temp_filtrada  (temp_filtrada),
    .salida_valida  (salida_valida),
    .falla_sensor   (falla_sensor),
    .estado         (estado)
  );

  typedef struct {
    logic vld;
    int   temp;
    int   est;
    logic falla;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the last N accepted samples, a state number and a reject run length.
  int m_est;
  int m_rech;
  int m_temp;
  int win[$];

  function automatic int floor_div(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    m_est  = 0;
    m_rech = 0;
    m_temp = 0;
    win.delete();
  endtask

  task automatic model_step(input logic v, input int x, output exp_t e);
    logic ok;
    int   s;
    e.vld = 1'b0;
    if (v) begin
      ok = (x >= LMIN) && (x <= LMAX);
`ifdef FILTRO_PICO_EN
      if (m_est == 1 && ((x > m_temp) ? (x - m_temp) : (m_temp - x)) > DELTA) ok = 1'b0;
`endif
      if (ok) begin
        if (m_est != 1) begin
          win.delete();
          for (int i = 0; i < N; i++) win.push_back(x);
        end else begin
          void'(win.pop_front());
          win.push_back(x);
        end
        s = 0;
        foreach (win[i]) s += win[i];
        m_temp = floor_div(s);
        m_rech = 0;
        m_est  = 1;
        e.vld  = 1'b1;
      end else begin
        m_rech = (m_rech + 1 > MAXR) ? MAXR : m_rech + 1;
        if (m_rech == MAXR) m_est = 2;
      end
    end
    e.temp  = m_temp;
    e.est   = m_est;
    e.falla = (m_est == 2);
  endtask

  task automatic send(input logic v, input int x);
    exp_t e;
    @(negedge clk);
    muestra_valida = v;
    muestra        = 11'(x);
    model_step(v, x, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_temp"}, int'($signed(temp_filtrada)), 0);
    chk({name, "_vld"}, int'(salida_valida), 0);
    chk({name, "_estado"}, int'(estado), 0);
    chk({name, "_falla"}, int'(falla_sensor), 0);
  endtask

  // Asynchronous assert between edges; outputs must clear before the next edge.
  task automatic reset_mid();
    @(negedge clk);
    muestra_valida = 1'b0;
    #2 arst_n = 1'b0;
    #1 check_zero("reset_async");
    model_reset();
    repeat (2) send(1'b0, 0);
    arst_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs after each edge against the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (salida_valida !== e.vld || int'($signed(temp_filtrada)) != e.temp ||
            int'(estado) != e.est || falla_sensor !== e.falla) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got vld=%0b temp=%0d est=%0d falla=%0b, expected vld=%0b temp=%0d est=%0d falla=%0b",
                   $time, salida_valida, $signed(temp_filtrada), estado, falla_sensor,
                   e.vld, e.temp, e.est, e.falla);
        end
      end
    end
  end

  initial begin
    int mode;
    int x;
    logic v;

    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset_init");
    @(negedge clk);
    arst_n = 1'b1;

    send(1'b1, 250);
    send(1'b0, 0);

    reset_mid();
    send(1'b1, 0);
    repeat (9) send(1'b1, 80);
    send(1'b0, -1024);

    reset_mid();
    send(1'b1, 40);

    reset_mid();
    send(1'b1, 0);
    send(1'b1, -3);
    send(1'b0, 0);

    send(1'b1, 1001);
    send(1'b1, -401);
    send(1'b0, 0);
    send(1'b1, 1023);
    send(1'b1, -1024);
    send(1'b1, 1500);
    send(1'b1, 200);
    send(1'b0, 0);

    reset_mid();
    send(1'b1, 1000);
    reset_mid();
    send(1'b1, -400);

`ifdef FILTRO_PICO_EN
    reset_mid();
    send(1'b1, 100);
    send(1'b1, 200);
    send(1'b1, 140);
    repeat (4) send(1'b1, 300);
    send(1'b1, 300);
`endif

    reset_mid();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) reset_mid();
      mode = int'($urandom_range(0, 9));
      v    = ($urandom_range(0, 9) < 7);
      if (mode < 6) begin
        x = int'($urandom_range(0, 1400)) - 400;
      end else if (mode < 8) begin
        x = m_temp + int'($urandom_range(0, 120)) - 60;
        if (x > 1023) x = 1023;
        if (x < -1024) x = -1024;
      end else begin
        x = int'($urandom_range(0, 2047)) - 1024;
      end
      send(v, x);
    end
    send(1'b0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
